// File: rtl/uart_baud_pkg.sv
// Shared rate codes and controller state encoding for the UART baud path.
package uart_baud_pkg;

    localparam logic [1:0] BAUD_2400  = 2'b00;
    localparam logic [1:0] BAUD_9600  = 2'b01;
    localparam logic [1:0] BAUD_19200 = 2'b10;
    localparam logic [1:0] BAUD_38400 = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_IDLE,
        ST_QUIESCE,
        ST_SETTLE
    } cfg_state_e;

endpackage

// File: rtl/uart_edge_det.sv
// Registered rising-edge detector for a signal already synchronous to clk_in.
module uart_edge_det (
    input  logic clk_in,
    input  logic rstn,
    input  logic sig,
    output logic rise
);

    logic sig_q;

    always_ff @(posedge clk_in or negedge rstn) begin
        if (!rstn) begin
            sig_q <= 1'b0;
        end else begin
            sig_q <= sig;
        end
    end

    assign rise = sig & ~sig_q;

endmodule

// File: rtl/baud_cfg_ctrl.sv
// Run-time baud-rate change sequencer: waits for TX/RX idle, quiesces the
// generator, applies the new select and waits for it to toggle before acking.
//
// state      | meaning
// -----------+------------------------------------------------------------
// IDLE       | rate stable, accepting cfg_req
// WAIT_IDLE  | new frames held off, waiting for TX and RX to finish
// QUIESCE    | generator held in reset while the new select settles
// SETTLE     | generator released, counting baud_clk rising edges
module baud_cfg_ctrl
    import uart_baud_pkg::*;
#(
    parameter int QUIESCE_CYCLES = 4,
    parameter int IDLE_TIMEOUT   = 1024,
    parameter int SETTLE_EDGES   = 2
) (
    input  logic       clk_in,
    input  logic       rstn,
    input  logic       cfg_req,
    input  logic [1:0] cfg_sel,
    input  logic       tx_busy,
    input  logic       rx_busy,
    input  logic       baud_clk,
    output logic [1:0] sel_out,
    output logic       gen_rstn,
    output logic       line_hold,
    output logic       cfg_busy,
    output logic       cfg_ack,
    output logic       cfg_err,
    output logic [1:0] cur_sel
);

    localparam int TMR_W  = $clog2(IDLE_TIMEOUT);
    localparam int ECNT_W = $clog2(SETTLE_EDGES + 1);
    localparam int QCNT_W = $clog2(QUIESCE_CYCLES + 1);

    localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'(IDLE_TIMEOUT - 1);
    localparam logic [ECNT_W-1:0] E_TARGET = ECNT_W'(SETTLE_EDGES);
    localparam logic [QCNT_W-1:0] Q_LAST   = QCNT_W'(QUIESCE_CYCLES - 1);

    cfg_state_e        state, state_nxt;
    logic [TMR_W-1:0]  timer, timer_nxt, timer_inc;
    logic [ECNT_W-1:0] e_cnt, e_cnt_nxt, e_cnt_inc;
    logic [QCNT_W-1:0] q_cnt, q_cnt_nxt;
    logic [1:0]        new_sel, new_sel_nxt;
    logic [1:0]        sel_out_q, sel_out_nxt;
    logic [1:0]        cur_sel_q, cur_sel_nxt;
    logic              gen_rstn_q, gen_rstn_nxt;
    logic              line_hold_q, line_hold_nxt;
    logic              busy_q, busy_nxt;
    logic              ack_q, ack_nxt;
    logic              err_q, err_nxt;
    logic              boot_q, boot_nxt;
    logic              baud_rise;

    uart_edge_det u_edge_det (
        .clk_in (clk_in),
        .rstn   (rstn),
        .sig    (baud_clk),
        .rise   (baud_rise)
    );

    assign timer_inc = (timer == TMR_LAST) ? timer : timer + 1'b1;
    assign e_cnt_inc = (e_cnt == E_TARGET) ? e_cnt : e_cnt + 1'b1;

    always_ff @(posedge clk_in or negedge rstn) begin
        if (!rstn) begin
            state       <= ST_QUIESCE;
            timer       <= '0;
            e_cnt       <= '0;
            q_cnt       <= '0;
            new_sel     <= BAUD_2400;
            sel_out_q   <= BAUD_2400;
            cur_sel_q   <= BAUD_2400;
            gen_rstn_q  <= 1'b0;
            line_hold_q <= 1'b1;
            busy_q      <= 1'b1;
            ack_q       <= 1'b0;
            err_q       <= 1'b0;
            boot_q      <= 1'b1;
        end else begin
            state       <= state_nxt;
            timer       <= timer_nxt;
            e_cnt       <= e_cnt_nxt;
            q_cnt       <= q_cnt_nxt;
            new_sel     <= new_sel_nxt;
            sel_out_q   <= sel_out_nxt;
            cur_sel_q   <= cur_sel_nxt;
            gen_rstn_q  <= gen_rstn_nxt;
            line_hold_q <= line_hold_nxt;
            busy_q      <= busy_nxt;
            ack_q       <= ack_nxt;
            err_q       <= err_nxt;
            boot_q      <= boot_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        timer_nxt     = timer;
        e_cnt_nxt     = e_cnt;
        q_cnt_nxt     = q_cnt;
        new_sel_nxt   = new_sel;
        sel_out_nxt   = sel_out_q;
        cur_sel_nxt   = cur_sel_q;
        gen_rstn_nxt  = gen_rstn_q;
        line_hold_nxt = line_hold_q;
        busy_nxt      = busy_q;
        ack_nxt       = 1'b0;
        err_nxt       = 1'b0;
        boot_nxt      = boot_q;

        case (state)
            ST_IDLE: begin
                if (cfg_req) begin
                    if (cfg_sel == cur_sel_q) begin
                        ack_nxt = 1'b1;
                    end else begin
                        new_sel_nxt   = cfg_sel;
                        timer_nxt     = '0;
                        state_nxt     = ST_WAIT_IDLE;
                        line_hold_nxt = 1'b1;
                        busy_nxt      = 1'b1;
                    end
                end
            end
            ST_WAIT_IDLE: begin
                // Idle wins over timeout when both land on the same cycle.
                if (!tx_busy && !rx_busy) begin
                    sel_out_nxt  = new_sel;
                    gen_rstn_nxt = 1'b0;
                    q_cnt_nxt    = '0;
                    state_nxt    = ST_QUIESCE;
                end else if (timer_inc == TMR_LAST) begin
                    err_nxt       = 1'b1;
                    state_nxt     = ST_IDLE;
                    line_hold_nxt = 1'b0;
                    busy_nxt      = 1'b0;
                end else begin
                    timer_nxt = timer_inc;
                end
            end
            ST_QUIESCE: begin
                if (q_cnt == Q_LAST) begin
                    gen_rstn_nxt = 1'b1;
                    e_cnt_nxt    = '0;
                    state_nxt    = ST_SETTLE;
                end else begin
                    q_cnt_nxt = q_cnt + 1'b1;
                end
            end
            ST_SETTLE: begin
                if (baud_rise) begin
                    if (e_cnt_inc == E_TARGET) begin
                        cur_sel_nxt   = sel_out_q;
                        ack_nxt       = ~boot_q;
                        boot_nxt      = 1'b0;
                        state_nxt     = ST_IDLE;
                        line_hold_nxt = 1'b0;
                        busy_nxt      = 1'b0;
                    end else begin
                        e_cnt_nxt = e_cnt_inc;
                    end
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    assign sel_out   = sel_out_q;
    assign cur_sel   = cur_sel_q;
    assign gen_rstn  = gen_rstn_q;
    assign line_hold = line_hold_q;
    assign cfg_busy  = busy_q;
    assign cfg_ack   = ack_q;
    assign cfg_err   = err_q;

endmodule

// File: tb/tb_baud_cfg_ctrl.sv
// Directed bench for baud_cfg_ctrl with hand-computed expectations.
module tb_baud_cfg_ctrl;

    logic       clk_in = 1'b0;
    logic       rstn = 1'b0;
    logic       cfg_req = 1'b0;
    logic [1:0] cfg_sel = 2'b00;
    logic       tx_busy = 1'b0;
    logic       rx_busy = 1'b0;
    logic       baud_clk = 1'b0;
    logic [1:0] sel_out;
    logic       gen_rstn;
    logic       line_hold;
    logic       cfg_busy;
    logic       cfg_ack;
    logic       cfg_err;
    logic [1:0] cur_sel;

    int n_tests = 0;
    int n_fail  = 0;
    int ack_seen = 0;
    int err_seen = 0;

    baud_cfg_ctrl dut (
        .clk_in    (clk_in),
        .rstn      (rstn),
        .cfg_req   (cfg_req),
        .cfg_sel   (cfg_sel),
        .tx_busy   (tx_busy),
        .rx_busy   (rx_busy),
        .baud_clk  (baud_clk),
        .sel_out   (sel_out),
        .gen_rstn  (gen_rstn),
        .line_hold (line_hold),
        .cfg_busy  (cfg_busy),
        .cfg_ack   (cfg_ack),
        .cfg_err   (cfg_err),
        .cur_sel   (cur_sel)
    );

    always #5 clk_in = ~clk_in;

    task automatic tick();
        @(posedge clk_in);
        #1;
        if (cfg_ack) ack_seen++;
        if (cfg_err) err_seen++;
        if (cfg_ack && cfg_err) begin
            n_tests++;
            n_fail++;
            $display("FAIL ack_err_overlap: cfg_ack=%0b cfg_err=%0b, required not both high", cfg_ack, cfg_err);
        end
    endtask

    task automatic baud_rise();
        baud_clk = 1'b0;
        tick();
        baud_clk = 1'b1;
        tick();
        baud_clk = 1'b0;
    endtask

    // Three cycles still low after QUIESCE entry, released on the fourth.
    task automatic check_quiesce(input string name);
        for (int i = 0; i < 3; i++) begin
            tick();
            n_tests++;
            if (gen_rstn !== 1'b0) begin
                n_fail++;
                $display("FAIL %s_gen_rstn_low[%0d]: got %0b want 0", name, i, gen_rstn);
            end
        end
        tick();
        n_tests++;
        if (gen_rstn !== 1'b1 || cfg_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_gen_rstn_release: gen_rstn=%0b cfg_busy=%0b want 1 1", name, gen_rstn, cfg_busy);
        end
    endtask

    task automatic test_reset();
        n_tests++;
        if (sel_out !== 2'b00 || cur_sel !== 2'b00 || gen_rstn !== 1'b0 || line_hold !== 1'b1 ||
            cfg_busy !== 1'b1 || cfg_ack !== 1'b0 || cfg_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_values: sel_out=%0d cur_sel=%0d gen_rstn=%0b line_hold=%0b busy=%0b ack=%0b err=%0b want 0 0 0 1 1 0 0",
                     sel_out, cur_sel, gen_rstn, line_hold, cfg_busy, cfg_ack, cfg_err);
        end
        ack_seen = 0;
        err_seen = 0;
        rstn = 1'b1;
        check_quiesce("boot");
        baud_rise();
        n_tests++;
        if (cfg_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL boot_busy_after_rise1: got %0b want 1", cfg_busy);
        end
        baud_rise();
        n_tests++;
        if (cfg_busy !== 1'b0 || cur_sel !== 2'b00 || line_hold !== 1'b0) begin
            n_fail++;
            $display("FAIL boot_settled: busy=%0b cur_sel=%0d line_hold=%0b want 0 0 0", cfg_busy, cur_sel, line_hold);
        end
        tick();
        n_tests++;
        if (ack_seen !== 0 || err_seen !== 0) begin
            n_fail++;
            $display("FAIL boot_no_ack: acks=%0d errs=%0d want 0 0", ack_seen, err_seen);
        end
    endtask

    task automatic test_switch();
        ack_seen = 0;
        cfg_sel = 2'b01;
        cfg_req = 1'b1;
        tick();
        cfg_req = 1'b0;
        n_tests++;
        if (line_hold !== 1'b1 || cfg_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL switch_accept: line_hold=%0b busy=%0b want 1 1", line_hold, cfg_busy);
        end
        tick();
        n_tests++;
        if (sel_out !== 2'b01 || gen_rstn !== 1'b0) begin
            n_fail++;
            $display("FAIL switch_apply: sel_out=%0d gen_rstn=%0b want 1 0", sel_out, gen_rstn);
        end
        check_quiesce("switch");
        baud_rise();
        n_tests++;
        if (ack_seen !== 0 || cur_sel !== 2'b00) begin
            n_fail++;
            $display("FAIL switch_rise1: acks=%0d cur_sel=%0d want 0 0", ack_seen, cur_sel);
        end
        baud_rise();
        n_tests++;
        if (cfg_ack !== 1'b1 || cur_sel !== 2'b01 || cfg_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL switch_ack: ack=%0b cur_sel=%0d busy=%0b want 1 1 0", cfg_ack, cur_sel, cfg_busy);
        end
        tick();
        n_tests++;
        if (cfg_ack !== 1'b0 || ack_seen !== 1) begin
            n_fail++;
            $display("FAIL switch_ack_pulse: ack=%0b acks=%0d want 0 1", cfg_ack, ack_seen);
        end
    endtask

    task automatic test_same_rate();
        cfg_sel = 2'b01;
        cfg_req = 1'b1;
        tick();
        cfg_req = 1'b0;
        n_tests++;
        if (cfg_ack !== 1'b1 || gen_rstn !== 1'b1 || cfg_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL same_rate_ack: ack=%0b gen_rstn=%0b busy=%0b want 1 1 0", cfg_ack, gen_rstn, cfg_busy);
        end
        tick();
        n_tests++;
        if (cfg_ack !== 1'b0 || gen_rstn !== 1'b1) begin
            n_fail++;
            $display("FAIL same_rate_after: ack=%0b gen_rstn=%0b want 0 1", cfg_ack, gen_rstn);
        end
    endtask

    task automatic test_timeout();
        int first_err = -1;
        ack_seen = 0;
        err_seen = 0;
        tx_busy = 1'b1;
        cfg_sel = 2'b10;
        cfg_req = 1'b1;
        tick();
        cfg_req = 1'b0;
        for (int n = 1; n < 2000; n++) begin
            tick();
            if (cfg_err && first_err < 0) first_err = n;
            if (n == 1022) begin
                n_tests++;
                if (line_hold !== 1'b1 || cfg_busy !== 1'b1) begin
                    n_fail++;
                    $display("FAIL timeout_hold: line_hold=%0b busy=%0b want 1 1", line_hold, cfg_busy);
                end
            end
        end
        tx_busy = 1'b0;
        n_tests++;
        if (first_err !== 1023 || err_seen !== 1 || ack_seen !== 0) begin
            n_fail++;
            $display("FAIL timeout_err: first_err_cycle=%0d errs=%0d acks=%0d want 1023 1 0", first_err, err_seen, ack_seen);
        end
        n_tests++;
        if (sel_out !== 2'b01 || cur_sel !== 2'b01 || line_hold !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_keep: sel_out=%0d cur_sel=%0d line_hold=%0b want 1 1 0", sel_out, cur_sel, line_hold);
        end
    endtask

    task automatic test_back_to_back();
        ack_seen = 0;
        err_seen = 0;
        rx_busy = 1'b1;
        cfg_sel = 2'b10;
        cfg_req = 1'b1;
        tick();
        cfg_req = 1'b0;
        for (int n = 1; n < 500; n++) tick();
        rx_busy = 1'b0;
        cfg_sel = 2'b11;
        cfg_req = 1'b1;
        tick();
        cfg_req = 1'b0;
        n_tests++;
        if (sel_out !== 2'b10 || gen_rstn !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_apply: sel_out=%0d gen_rstn=%0b want 2 0", sel_out, gen_rstn);
        end
        check_quiesce("b2b");
        baud_rise();
        baud_rise();
        for (int n = 0; n < 6; n++) tick();
        n_tests++;
        if (cur_sel !== 2'b10 || ack_seen !== 1 || err_seen !== 0 || cfg_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_done: cur_sel=%0d acks=%0d errs=%0d busy=%0b want 2 1 0 0", cur_sel, ack_seen, err_seen, cfg_busy);
        end
    endtask

    task automatic test_reset_abort();
        cfg_sel = 2'b11;
        cfg_req = 1'b1;
        tick();
        cfg_req = 1'b0;
        tick();
        n_tests++;
        if (sel_out !== 2'b11 || gen_rstn !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_quiesce: sel_out=%0d gen_rstn=%0b want 3 0", sel_out, gen_rstn);
        end
        tick();
        ack_seen = 0;
        err_seen = 0;
        #2;
        rstn = 1'b0;
        #1;
        n_tests++;
        if (sel_out !== 2'b00 || cur_sel !== 2'b00 || gen_rstn !== 1'b0 || line_hold !== 1'b1 ||
            cfg_busy !== 1'b1 || cfg_ack !== 1'b0 || cfg_err !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_reset_values: sel_out=%0d cur_sel=%0d gen_rstn=%0b line_hold=%0b busy=%0b ack=%0b err=%0b want 0 0 0 1 1 0 0",
                     sel_out, cur_sel, gen_rstn, line_hold, cfg_busy, cfg_ack, cfg_err);
        end
        @(posedge clk_in);
        #1;
        rstn = 1'b1;
        check_quiesce("abort");
        baud_rise();
        baud_rise();
        tick();
        n_tests++;
        if (cfg_busy !== 1'b0 || cur_sel !== 2'b00 || sel_out !== 2'b00 || ack_seen !== 0 || err_seen !== 0) begin
            n_fail++;
            $display("FAIL abort_resettle: busy=%0b cur_sel=%0d sel_out=%0d acks=%0d errs=%0d want 0 0 0 0 0",
                     cfg_busy, cur_sel, sel_out, ack_seen, err_seen);
        end
    endtask

    initial begin
        rstn = 1'b0;
        repeat (2) @(posedge clk_in);
        #1;
        test_reset();
        test_switch();
        test_same_rate();
        test_timeout();
        test_back_to_back();
        test_reset_abort();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/baud_cfg_ctrl.md
Name: baud_cfg_ctrl

Overview:
Run-time baud-rate configuration controller that owns the select and reset inputs of the UART baud generator. Accepts rate-change requests from the register/host side and waits for the TX and RX engines to go idle. It then quiesces the generator, applies the new select, and confirms the generator is toggling before acknowledging. Sits between the host config interface, the TX/RX engines and the baud generator; everything runs in the clk_in domain.

Parameters:
QUIESCE_CYCLES, 4, cycles the generator is held in reset while the select changes (min 1)
IDLE_TIMEOUT, 1024, max cycles spent waiting for TX/RX idle before rejecting the request (min 2)
SETTLE_EDGES, 2, rising edges of baud_clk required after release before ack (min 1)

Ports:
clk_in  input  1  system clock, also the generator source clock
rstn  input  1  asynchronous active-low reset
cfg_req  input  1  request strobe; sampled only in IDLE; one-cycle pulse is sufficient
cfg_sel  input  2  requested rate code, captured with cfg_req
tx_busy  input  1  TX engine mid-frame
rx_busy  input  1  RX engine mid-frame
baud_clk  input  1  generator output (clk_out), synchronous to clk_in
sel_out  output  2  select driven to generator
gen_rstn  output  1  active-low reset driven to generator
line_hold  output  1  TX must not start a new frame while high
cfg_busy  output  1  high in any state other than IDLE
cfg_ack  output  1  one-cycle pulse: new rate active
cfg_err  output  1  one-cycle pulse: request rejected on idle timeout
cur_sel  output  2  currently active rate code

Behaviour:
- Clock and reset: one clock, clk_in. Reset is asynchronous, active-low (rstn). All outputs are registered.
- Reset values: sel_out=00, cur_sel=00, gen_rstn=0, line_hold=1, cfg_busy=1, cfg_ack=0, cfg_err=0. The state register resets to QUIESCE with its counter at 0, so every reset runs a full power-up quiesce/settle at rate 00.
- Asserting rstn mid-operation aborts any request: no ack or err is issued and the new code is discarded.
- States: IDLE, WAIT_IDLE, QUIESCE, SETTLE.
- IDLE (line_hold=0, cfg_busy=0):
  - cfg_req=1 and cfg_sel==cur_sel: stay in IDLE and pulse cfg_ack next cycle (no-op; generator untouched).
  - cfg_req=1 and cfg_sel!=cur_sel: latch new_sel, clear timer, go to WAIT_IDLE.
- WAIT_IDLE (line_hold=1):
  - tx_busy==0 and rx_busy==0 in the same cycle: set sel_out=new_sel, gen_rstn=0, go to QUIESCE. This takes priority over timeout on the same cycle.
  - Otherwise the timer increments. When the timer reaches IDLE_TIMEOUT-1 without idle: pulse cfg_err, go to IDLE; sel_out and cur_sel are unchanged.
- QUIESCE: gen_rstn=0 for exactly QUIESCE_CYCLES cycles, then gen_rstn=1, clear the edge counter, go to SETTLE.
- SETTLE:
  - Count rising edges of baud_clk, detected as registered previous value 0 and current 1.
  - On the SETTLE_EDGES-th edge: cur_sel=sel_out, pulse cfg_ack (suppressed for the post-reset settle), go to IDLE.
  - SETTLE has no timeout.
- cfg_req outside IDLE is ignored: not queued, no err.
- cfg_ack and cfg_err are never high in the same cycle.
- Timer width: $clog2(IDLE_TIMEOUT). Edge counter width: $clog2(SETTLE_EDGES+1). Both saturate and never wrap.

Decomposition:
- Package uart_baud_pkg holds:
  - rate-code constants BAUD_2400=2'b00, BAUD_9600=2'b01, BAUD_19200=2'b10, BAUD_38400=2'b11
  - the controller state enum
- One sub-module: uart_edge_det (registered rising-edge detector on baud_clk). It is reusable by the RX sampler.
- The baud generator is instantiated alongside this block, not inside it.

Test Plan:
- Reset release, baud_clk toggling → gen_rstn low 4 cycles, high after; cfg_busy drops after 2nd baud_clk rise; no cfg_ack; cur_sel=00.
- Idle UART, cfg_req with cfg_sel=01 → sel_out=01 with gen_rstn=0 the cycle after acceptance; cfg_ack after 2 baud_clk rises; cur_sel=01.
- cfg_req with cfg_sel=cur_sel=01 → cfg_ack exactly one cycle later; gen_rstn stays 1.
- tx_busy held high 2000 cycles, cfg_req sel=10 → line_hold=1; cfg_err pulse 1023 cycles after acceptance; sel_out and cur_sel remain 01.
- rx_busy drops at cycle 500 of WAIT_IDLE while cfg_req pulses again → second request ignored; switch proceeds, single cfg_ack.
- rstn asserted during QUIESCE after a request for 11 → outputs return to reset values immediately; no ack/err; cur_sel=00 after re-settle.
